vproc_fetch_seq: RTL and testbench

- Multi-operand vector register-group fetch sequencer between decode and execution units.
- Accepts one micro-op descriptor per handshake: EMUL, up to N_OPS source operands, destination.
- Steps through every register of the group, one OP_W-bit beat per cycle, emitting per-operand address, fetch, shift and hazard-clear strobes.
- Generalises the existing single-operand fetch_info helpers: adds channel count, width, narrowing and back-pressure.

---
 rtl/vproc_pkg.sv | 27 ++
 rtl/vproc_skid_buf.sv | 45 ++++
 rtl/vproc_fetch_seq.sv | 158 +++++++++++++++
 tb/tb_vproc_fetch_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// Shared types for the vector processor fetch path: group size encoding,
// sequencer states and the per-operand strobe bundle.
package vproc_pkg;

  typedef enum logic [1:0] {
    EMUL_1 = 2'd0,
    EMUL_2 = 2'd1,
    EMUL_4 = 2'd2,
    EMUL_8 = 2'd3
  } cfg_emul;

  typedef enum logic {
    FSEQ_IDLE = 1'b0,
    FSEQ_RUN  = 1'b1
  } fetch_seq_state;

  typedef struct packed {
    logic fetch;
    logic shift;
    logic clear_hazard;
  } fetch_info;

  function automatic logic [3:0] emul_vregs(cfg_emul emul);
    return 4'd1 << emul;
  endfunction

endpackage

// File: rtl/vproc_skid_buf.sv
// Two-entry skid register with valid/ready on both sides; in_ready comes
// only from the fill level, so upstream never sees out_ready combinationally.
module vproc_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         sync_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/vproc_fetch_seq.sv
// Register-group fetch sequencer: one OP_W beat per cycle across an EMUL group
// for up to N_OPS operands. Define VPROC_FETCH_SEQ_SKID_EN to register all out_* through a skid buffer.
module vproc_fetch_seq
  import vproc_pkg::*;
#(
  parameter int N_OPS  = 2,
  parameter int VREG_W = 128,
  parameter int OP_W   = 32
) (
  input  logic               clk_i,
  input  logic               sync_rst_ni,
  input  logic               op_valid_i,
  output logic               op_ready_o,
  input  logic [1:0]         op_emul_i,
  input  logic [N_OPS-1:0]   op_vreg_i,
  input  logic [5*N_OPS-1:0] op_base_i,
  input  logic [N_OPS-1:0]   op_narrow_i,
  input  logic [4:0]         op_vd_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [5*N_OPS-1:0] out_vaddr_o,
  output logic [N_OPS-1:0]   out_fetch_o,
  output logic [N_OPS-1:0]   out_shift_o,
  output logic [N_OPS-1:0]   out_clear_hazard_o,
  output logic [4:0]         out_vd_o,
  output logic               out_first_o,
  output logic               out_last_o
);

  localparam int BEATS  = VREG_W / OP_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int BEAT_W = 8 * N_OPS + 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

  fetch_seq_state state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mul_q, mul_d;
  cfg_emul          emul_q;
  logic [N_OPS-1:0]   vreg_q, narrow_q;
  logic [5*N_OPS-1:0] base_q;
  logic [4:0]         vd_q;

  logic run, last, first, load, beat_ready;
  fetch_info          info [N_OPS];
  logic [5*N_OPS-1:0] vaddr;
  logic [N_OPS-1:0]   fetch, shift, clr;
  logic [4:0]         vd;
  logic [BEAT_W-1:0]  beat;

  assign run   = state_q == FSEQ_RUN;
  assign last  = run && ({1'b0, mul_q} == emul_vregs(emul_q) - 4'd1) && (cnt_q == CNT_MAX);
  assign first = run && (mul_q == 3'd0) && (cnt_q == '0);
  // A new op can load in the same cycle the final beat is consumed.
  assign op_ready_o = !run || (last && beat_ready);
  assign load       = op_valid_i && op_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    if (run && beat_ready) begin
      if (last) begin
        state_d = FSEQ_IDLE;
        cnt_d   = '0;
        mul_d   = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        mul_d = mul_q + 3'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (load) begin
      state_d = FSEQ_RUN;
      cnt_d   = '0;
      mul_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      state_q  <= FSEQ_IDLE;
      cnt_q    <= '0;
      mul_q    <= '0;
      emul_q   <= EMUL_1;
      vreg_q   <= '0;
      narrow_q <= '0;
      base_q   <= '0;
      vd_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      if (load) begin
        emul_q   <= cfg_emul'(op_emul_i);
        vreg_q   <= op_vreg_i;
        narrow_q <= op_narrow_i;
        base_q   <= op_base_i;
        vd_q     <= op_vd_i;
      end
    end
  end

  // A narrow source vreg covers two destination vregs, so it advances on every other mul.
  always_comb begin
    vaddr = '0;
    fetch = '0;
    shift = '0;
    clr   = '0;
    for (int k = 0; k < N_OPS; k++) begin
      info[k] = '0;
      if (run && vreg_q[k]) begin
        if (narrow_q[k]) begin
          vaddr[5*k +: 5]      = base_q[5*k +: 5] | {3'b000, mul_q[2:1]};
          info[k].fetch        = (cnt_q == '0) && !mul_q[0];
          info[k].shift        = cnt_q[0];
          info[k].clear_hazard = (cnt_q == CNT_MAX) && (mul_q[0] || last);
        end else begin
          vaddr[5*k +: 5]      = base_q[5*k +: 5] | {2'b00, mul_q};
          info[k].fetch        = cnt_q == '0;
          info[k].shift        = cnt_q != '0;
          info[k].clear_hazard = cnt_q == CNT_MAX;
        end
      end
      fetch[k] = info[k].fetch;
      shift[k] = info[k].shift;
      clr[k]   = info[k].clear_hazard;
    end
  end

  assign vd   = run ? (vd_q | {2'b00, mul_q}) : 5'd0;
  assign beat = {vaddr, fetch, shift, clr, vd, first, last};

`ifdef VPROC_FETCH_SEQ_SKID_EN
  logic [BEAT_W-1:0] skid_data;

  vproc_skid_buf #(.W(BEAT_W)) u_skid (
    .clk        (clk_i),
    .sync_rst_n (sync_rst_ni),
    .in_valid   (run),
    .in_ready   (beat_ready),
    .in_data    (beat),
    .out_valid  (out_valid_o),
    .out_ready  (out_ready_i),
    .out_data   (skid_data)
  );

  // Stale entries stay in the buffer; mask so strobes read 0 while empty.
  assign {out_vaddr_o, out_fetch_o, out_shift_o, out_clear_hazard_o,
          out_vd_o, out_first_o, out_last_o} = skid_data & {BEAT_W{out_valid_o}};
`else
  assign beat_ready  = out_ready_i;
  assign out_valid_o = run;
  assign {out_vaddr_o, out_fetch_o, out_shift_o, out_clear_hazard_o,
          out_vd_o, out_first_o, out_last_o} = beat;
`endif

endmodule

// File: tb/tb_vproc_fetch_seq.sv
// Self-checking bench for vproc_fetch_seq (default build): directed scenarios
// plus randomized ops/back-pressure against a beat-index reference model.
module tb_vproc_fetch_seq;

  localparam int N_OPS  = 2;
  localparam int VREG_W = 128;
  localparam int OP_W   = 32;
  localparam int BEATS  = VREG_W / OP_W;

  logic               clk_i = 1'b0;
  logic               sync_rst_ni;
  logic               op_valid_i;
  logic               op_ready_o;
  logic [1:0]         op_emul_i;
  logic [N_OPS-1:0]   op_vreg_i;
  logic [5*N_OPS-1:0] op_base_i;
  logic [N_OPS-1:0]   op_narrow_i;
  logic [4:0]         op_vd_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [5*N_OPS-1:0] out_vaddr_o;
  logic [N_OPS-1:0]   out_fetch_o;
  logic [N_OPS-1:0]   out_shift_o;
  logic [N_OPS-1:0]   out_clear_hazard_o;
  logic [4:0]         out_vd_o;
  logic               out_first_o;
  logic               out_last_o;

  int checks   = 0;
  int failures = 0;

  vproc_fetch_seq #(.N_OPS(N_OPS), .VREG_W(VREG_W), .OP_W(OP_W)) dut (
    .clk_i              (clk_i),
    .sync_rst_ni        (sync_rst_ni),
    .op_valid_i         (op_valid_i),
    .op_ready_o         (op_ready_o),
    .op_emul_i          (op_emul_i),
    .op_vreg_i          (op_vreg_i),
    .op_base_i          (op_base_i),
    .op_narrow_i        (op_narrow_i),
    .op_vd_i            (op_vd_i),
    .out_valid_o        (out_valid_o),
    .out_ready_i        (out_ready_i),
    .out_vaddr_o        (out_vaddr_o),
    .out_fetch_o        (out_fetch_o),
    .out_shift_o        (out_shift_o),
    .out_clear_hazard_o (out_clear_hazard_o),
    .out_vd_o           (out_vd_o),
    .out_first_o        (out_first_o),
    .out_last_o         (out_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]         emul;
    logic [N_OPS-1:0]   vreg;
    logic [N_OPS-1:0]   narrow;
    logic [5*N_OPS-1:0] base;
    logic [4:0]         vd;
  } desc_t;

  typedef struct packed {
    logic [5*N_OPS-1:0] vaddr;
    logic [N_OPS-1:0]   fetch;
    logic [N_OPS-1:0]   shift;
    logic [N_OPS-1:0]   clr;
    logic [4:0]         vd;
    logic               first;
    logic               last;
  } beat_t;

  desc_t q[$];

  function automatic int op_beats(desc_t d);
    return (1 << d.emul) * BEATS;
  endfunction

  // Beat b of an op: destination vreg b/BEATS; a narrow source vreg spans 2*BEATS beats.
  function automatic beat_t model_beat(desc_t d, int b);
    beat_t e;
    int total, grp, pos, src, lead;
    logic [4:0] bk;
    e     = '0;
    total = op_beats(d);
    grp   = b / BEATS;
    pos   = b % BEATS;
    for (int k = 0; k < N_OPS; k++) begin
      bk = d.base[5*k +: 5];
      if (d.vreg[k]) begin
        if (d.narrow[k]) begin
          src  = b / (2 * BEATS);
          lead = b % (2 * BEATS);
          e.vaddr[5*k +: 5] = bk | 5'(src);
          e.fetch[k] = (lead == 0);
          e.shift[k] = (b % 2) == 1;
          e.clr[k]   = (lead == 2 * BEATS - 1) || (b == total - 1);
        end else begin
          e.vaddr[5*k +: 5] = bk | 5'(grp);
          e.fetch[k] = (pos == 0);
          e.shift[k] = (pos != 0);
          e.clr[k]   = (pos == BEATS - 1);
        end
      end
    end
    e.vd    = d.vd | 5'(grp);
    e.first = (b == 0);
    e.last  = (b == total - 1);
    return e;
  endfunction

  function automatic desc_t mk(logic [1:0] emul, logic [N_OPS-1:0] vreg, logic [N_OPS-1:0] narrow,
                               logic [4:0] b0, logic [4:0] b1, logic [4:0] vd);
    desc_t d;
    d.emul = emul; d.vreg = vreg; d.narrow = narrow; d.base = {b1, b0}; d.vd = vd;
    return d;
  endfunction

  // ready_mode: 0 always ready, 1 three stall cycles at beat 2, 2 random
  task automatic run_engine(input string tag, input int ready_mode, input bit valid_gaps, input int budget);
    desc_t cur;
    beat_t got, exp;
    int b = 0, cycles = 0, stall_left = 3, exp_beats = 0, got_beats = 0;
    bit busy = 1'b0, exp_ready, accept;
    cur = mk(2'd0, '0, '0, 5'd0, 5'd0, 5'd0);
    while ((q.size() > 0 || busy) && cycles < budget) begin
      @(negedge clk_i);
      if (q.size() > 0 && (!valid_gaps || $urandom_range(0, 3) != 0)) begin
        op_valid_i  = 1'b1;
        op_emul_i   = q[0].emul;
        op_vreg_i   = q[0].vreg;
        op_narrow_i = q[0].narrow;
        op_base_i   = q[0].base;
        op_vd_i     = q[0].vd;
      end else begin
        op_valid_i  = 1'b0;
        op_emul_i   = 2'($urandom);
        op_vreg_i   = N_OPS'($urandom);
        op_narrow_i = N_OPS'($urandom);
        op_base_i   = (5*N_OPS)'($urandom);
        op_vd_i     = 5'($urandom);
      end
      out_ready_i = 1'b1;
      if (ready_mode == 1 && busy && b == 2 && stall_left > 0) begin
        out_ready_i = 1'b0;
        stall_left--;
      end else if (ready_mode == 2) begin
        out_ready_i = 1'($urandom_range(0, 1));
      end
      #1;
      checks++;
      if (out_valid_o !== busy) begin
        failures++;
        $display("FAIL %s valid cyc=%0d got=%b exp=%b", tag, cycles, out_valid_o, busy);
      end
      if (busy) begin
        got = {out_vaddr_o, out_fetch_o, out_shift_o, out_clear_hazard_o, out_vd_o, out_first_o, out_last_o};
        exp = model_beat(cur, b);
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL %s beat b=%0d got=%h exp=%h", tag, b, got, exp);
        end
      end
      exp_ready = !busy || (b == op_beats(cur) - 1 && out_ready_i);
      checks++;
      if (op_ready_o !== exp_ready) begin
        failures++;
        $display("FAIL %s op_ready cyc=%0d got=%b exp=%b", tag, cycles, op_ready_o, exp_ready);
      end
      if (out_valid_o === 1'b1 && out_ready_i) got_beats++;
      accept = op_valid_i && exp_ready;
      if (busy && out_ready_i) begin
        b++;
        if (b == op_beats(cur)) busy = 1'b0;
      end
      if (accept) begin
        cur = q.pop_front();
        busy = 1'b1;
        b = 0;
        exp_beats += op_beats(cur);
      end
      cycles++;
    end
    checks++;
    if (cycles >= budget) begin
      failures++;
      $display("FAIL %s timeout got=%0d cycles exp=<%0d", tag, cycles, budget);
    end
    checks++;
    if (got_beats != exp_beats) begin
      failures++;
      $display("FAIL %s beat_count got=%0d exp=%0d", tag, got_beats, exp_beats);
    end
    @(negedge clk_i);
    op_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    sync_rst_ni = 1'b0; op_valid_i = 1'b0; out_ready_i = 1'b0;
    op_emul_i = '0; op_vreg_i = '0; op_narrow_i = '0; op_base_i = '0; op_vd_i = '0;
    repeat (3) @(negedge clk_i);
    sync_rst_ni = 1'b1;
    #1;
    checks++;
    if ({out_valid_o, op_ready_o, out_fetch_o, out_shift_o, out_clear_hazard_o, out_first_o, out_last_o} !==
        {1'b0, 1'b1, {(3*N_OPS){1'b0}}, 2'b00}) begin
      failures++;
      $display("FAIL reset valid=%b ready=%b f=%b s=%b c=%b first=%b last=%b exp valid=0 ready=1 rest 0",
               out_valid_o, op_ready_o, out_fetch_o, out_shift_o, out_clear_hazard_o, out_first_o, out_last_o);
    end
  endtask

  task automatic test_emul1_scalar();
    q.push_back(mk(2'd0, 2'b01, 2'b00, 5'd8, 5'd3, 5'd0));
    run_engine("emul1_scalar", 0, 1'b0, 50);
  endtask

  task automatic test_emul4_narrow();
    q.push_back(mk(2'd2, 2'b11, 2'b10, 5'd16, 5'd4, 5'd24));
    run_engine("emul4_narrow", 0, 1'b0, 100);
  endtask

  task automatic test_stall();
    q.push_back(mk(2'd1, 2'b11, 2'b10, 5'd2, 5'd6, 5'd10));
    run_engine("stall", 1, 1'b0, 100);
  endtask

  task automatic test_back_to_back();
    q.push_back(mk(2'd0, 2'b11, 2'b00, 5'd8, 5'd12, 5'd1));
    q.push_back(mk(2'd0, 2'b11, 2'b11, 5'd20, 5'd14, 5'd5));
    q.push_back(mk(2'd1, 2'b10, 2'b10, 5'd0, 5'd30, 5'd22));
    run_engine("back_to_back", 0, 1'b0, 100);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk_i);
    op_valid_i = 1'b1; op_emul_i = 2'd3; op_vreg_i = 2'b01; op_narrow_i = 2'b00;
    op_base_i = {5'd0, 5'd0}; op_vd_i = 5'd0; out_ready_i = 1'b1;
    @(negedge clk_i);
    op_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #1;
    checks++;
    if (out_valid_o !== 1'b1 || out_vaddr_o[4:0] !== 5'd1) begin
      failures++;
      $display("FAIL rst_mid_beat5 valid=%b vaddr0=%0d exp valid=1 vaddr0=1", out_valid_o, out_vaddr_o[4:0]);
    end
    sync_rst_ni = 1'b0;
    @(negedge clk_i);
    sync_rst_ni = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || op_ready_o !== 1'b1 || out_fetch_o !== '0 || out_shift_o !== '0) begin
      failures++;
      $display("FAIL rst_mid valid=%b ready=%b fetch=%b shift=%b exp 0 1 0 0",
               out_valid_o, op_ready_o, out_fetch_o, out_shift_o);
    end
    q.push_back(mk(2'd0, 2'b01, 2'b00, 5'd8, 5'd0, 5'd0));
    run_engine("after_reset", 0, 1'b0, 50);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      q.push_back(mk(2'($urandom), N_OPS'($urandom), N_OPS'($urandom),
                     5'($urandom), 5'($urandom), 5'($urandom)));
    run_engine("random", 2, 1'b1, 6000);
  endtask

  initial begin
    test_reset();
    test_emul1_scalar();
    test_emul4_narrow();
    test_stall();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
